// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud-derived timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_pulse_width(input int clk_freq, input int baud_rate);
    return pulse_width(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB first, one-word output register with overrun/frame-error pulses.
// Word appears one cycle after the stop-bit sample; a held word is never overwritten (new word dropped).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int CW               = $clog2(PULSE_WIDTH) + 1;
  localparam int IW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] FULL_LOAD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PULSE_WIDTH - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

  logic line;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_signal),
    .q       (line)
  );

  uart_state_e           state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  rx_valid_n, frame_err_n, overrun_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (ena) begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    if (rx_valid && rx_ready) rx_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (!line) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!line) begin
          state_n   = DATA;
          cnt_n     = FULL_LOAD;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          // Right shift so the first (LSB) bit ends up at position 0.
          shift_n                 = shift >> 1;
          shift_n[DATA_WIDTH-1]   = line;
          cnt_n                   = FULL_LOAD;
          if (bit_idx == LAST_BIT) state_n = STOP;
          else                     bit_idx_n = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (line) begin
          state_n = IDLE;
          if (!rx_valid || rx_ready) begin
            rx_data_n  = shift;
            rx_valid_n = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end else begin
          frame_err_n = 1'b1;
          state_n     = BREAK;
        end
      end
      BREAK: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a monitor pops on each new rx_valid.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int BIT = 10;

  logic          clk = 1'b0;
  logic          reset_n, ena, rx_signal, rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int v_cyc    = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .rx_signal (rx_signal),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop, input int bclk, input int hold_low);
    rx_signal = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_signal = data[i];
      repeat (bclk) @(negedge clk);
    end
    rx_signal = stop;
    repeat (bclk) @(negedge clk);
    repeat (hold_low) @(negedge clk);
    rx_signal = 1'b1;
    repeat (2 * bclk) @(negedge clk);
  endtask

  // Monitor: pops one expected word per new rx_valid and tallies pulse cycles.
  initial begin
    logic prev_v;
    logic [DW-1:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data_word", 32'(rx_data), 32'(e));
        end
      end
      if (frame_err && overrun) check("pulse_exclusive", 32'(1), 32'(0));
      prev_v = rx_valid;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rx_valid)  v_cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, v0, wait_n;
    bit done;
    reset_n   = 1'b0;
    ena       = 1'b1;
    rx_signal = 1'b1;
    rx_ready  = 1'b1;
    #1;
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_overrun", 32'(overrun), 32'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame with consumer always ready
    fe0 = fe_cnt; v0 = v_cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT, 0);
    check("a5_valid_cycles", 32'(v_cyc - v0), 32'(1));
    check("a5_frame_err", 32'(fe_cnt - fe0), 32'(0));

    // Short glitch rejected at start-bit midpoint
    v0 = v_cyc;
    rx_signal = 1'b0;
    repeat (3) @(negedge clk);
    rx_signal = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_no_valid", 32'(v_cyc - v0), 32'(0));
    check("glitch_state_idle", 32'(dut.state), 32'(IDLE));

    // Bad stop bit, line held low (break), then a good frame
    fe0 = fe_cnt; v0 = v_cyc;
    send_frame(8'h3C, 1'b0, BIT, 30);
    check("break_frame_err", 32'(fe_cnt - fe0), 32'(1));
    check("break_no_valid", 32'(v_cyc - v0), 32'(0));
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT, 0);

    // Overrun: second word dropped while first is held
    ov0 = ov_cnt; fe0 = fe_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT, 0);
    send_frame(8'h22, 1'b1, BIT, 0);
    check("ovr_rx_data_held", 32'(rx_data), 32'(8'h11));
    check("ovr_rx_valid_held", 32'(rx_valid), 32'(1));
    check("ovr_pulse_count", 32'(ov_cnt - ov0), 32'(1));
    check("ovr_no_frame_err", 32'(fe_cnt - fe0), 32'(0));
    rx_ready = 1'b1;
    @(negedge clk);
    check("accept_clears_valid", 32'(rx_valid), 32'(0));
    check("accept_keeps_data", 32'(rx_data), 32'(8'h11));

    // Reset during the data bits of 0xFF
    rx_signal = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_signal = 1'b1;
    repeat (4 * BIT + 3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_rx_data", 32'(rx_data), 32'(0));
    check("midreset_rx_valid", 32'(rx_valid), 32'(0));
    check("midreset_frame_err", 32'(frame_err), 32'(0));
    check("midreset_overrun", 32'(overrun), 32'(0));
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5 * BIT) @(negedge clk);
    check("midreset_no_valid", 32'(rx_valid), 32'(0));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT, 0);

    // Clock enable at 50% duty with half-rate line
    exp_q.push_back(8'h6E);
    done = 1'b0;
    fork
      begin
        send_frame(8'h6E, 1'b1, 2 * BIT, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ena = ~ena;
        end
        ena = 1'b1;
      end
    join

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
